axis_peak_argmax: RTL

Downstream stage of the burst peak detector. It consumes each captured burst of NUM_CHANNELS complex samples, delimited by tlast, and finds the location and size of the strongest sample in every channel. For each burst it emits a single summary beat: per channel, the sample index of the maximum L1 magnitude (|I|+|Q|) and that magnitude. This summary feeds the angle/phase estimation logic.

---
 rtl/axis_peak_argmax_pkg.sv | 21 ++
 rtl/cplx_mag_l1.sv | 24 ++
 rtl/axis_peak_argmax.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/axis_peak_argmax_pkg.sv
// Shared definitions for the burst peak/argmax summary stage: summary field
// layout, tuser flag positions and the controller state encoding.
package axis_peak_argmax_pkg;

    localparam int INDEX_WIDTH     = 16;
    localparam int TUSER_WIDTH     = 2;
    localparam int TUSER_SHORT_BIT = 0;
    localparam int TUSER_LONG_BIT  = 1;

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_OUTPUT  = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    // Beat counter width; a one-beat burst still needs a 1-bit counter.
    function automatic int count_width(input int burst_length);
        return (burst_length > 1) ? $clog2(burst_length) : 1;
    endfunction

endpackage

// File: rtl/cplx_mag_l1.sv
// L1 magnitude |I|+|Q| of one complex sample; I in the low half, Q in the high half.
module cplx_mag_l1 #(
    parameter int CHANNEL_WIDTH = 64
) (
    input  logic [CHANNEL_WIDTH-1:0] i_sample,
    output logic [CHANNEL_WIDTH/2:0] o_mag
);
    localparam int HALF_W = CHANNEL_WIDTH / 2;

    logic [HALF_W-1:0] w_i;
    logic [HALF_W-1:0] w_q;
    logic [HALF_W-1:0] w_abs_i;
    logic [HALF_W-1:0] w_abs_q;

    assign w_i = i_sample[HALF_W-1:0];
    assign w_q = i_sample[CHANNEL_WIDTH-1:HALF_W];

    // Unsigned reinterpretation makes |-2^(HALF_W-1)| land exactly on 2^(HALF_W-1).
    assign w_abs_i = w_i[HALF_W-1] ? (~w_i + HALF_W'(1)) : w_i;
    assign w_abs_q = w_q[HALF_W-1] ? (~w_q + HALF_W'(1)) : w_q;

    assign o_mag = {1'b0, w_abs_i} + {1'b0, w_abs_q};

endmodule

// File: rtl/axis_peak_argmax.sv
// Per-burst, per-channel peak L1 magnitude and its beat index, emitted as one
// AXI-Stream summary beat; overlong bursts are truncated and their tail dropped.
module axis_peak_argmax
    import axis_peak_argmax_pkg::*;
#(
    parameter int NUM_CHANNELS  = 4,
    parameter int CHANNEL_WIDTH = 64,
    parameter int BURST_LENGTH  = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  s_axis_tvalid,
    output logic                                  s_axis_tready,
    input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] s_axis_tdata,
    input  logic                                  s_axis_tlast,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] m_axis_tdata,
    output logic [TUSER_WIDTH-1:0]                m_axis_tuser
);
    localparam int MAG_WIDTH = CHANNEL_WIDTH / 2 + 1;
    localparam int CNT_W     = count_width(BURST_LENGTH);
    localparam int DATA_W    = NUM_CHANNELS * CHANNEL_WIDTH;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [CNT_W-1:0]         r_count;
    logic [MAG_WIDTH-1:0]     r_max [NUM_CHANNELS];
    logic [INDEX_WIDTH-1:0]   r_idx [NUM_CHANNELS];
    logic                     r_discard;
    logic                     r_s_tready;
    logic                     r_m_tvalid;
    logic [DATA_W-1:0]        r_m_tdata;
    logic [TUSER_WIDTH-1:0]   r_m_tuser;

    logic [MAG_WIDTH-1:0]     w_mag     [NUM_CHANNELS];
    logic [MAG_WIDTH-1:0]     w_new_max [NUM_CHANNELS];
    logic [INDEX_WIDTH-1:0]   w_new_idx [NUM_CHANNELS];
    logic [DATA_W-1:0]        w_summary;
    logic                     w_s_hs;
    logic                     w_m_hs;
    logic                     w_last_slot;
    logic                     w_burst_end;
    logic                     w_long;
    logic                     w_short;
    logic [TUSER_WIDTH-1:0]   w_tuser;

    function automatic logic [CHANNEL_WIDTH-1:0] pack_field(
        input logic [INDEX_WIDTH-1:0] idx,
        input logic [MAG_WIDTH-1:0]   mag
    );
        logic [CHANNEL_WIDTH-1:0] f;
        f                                        = '0;
        f[MAG_WIDTH-1:0]                         = mag;
        f[CHANNEL_WIDTH-1 -: INDEX_WIDTH]        = idx;
        return f;
    endfunction

    assign w_s_hs      = s_axis_tvalid && r_s_tready;
    assign w_m_hs      = r_m_tvalid && m_axis_tready;
    assign w_last_slot = (r_count == CNT_W'(BURST_LENGTH - 1));
    assign w_burst_end = s_axis_tlast || w_last_slot;
    assign w_long      = w_last_slot && !s_axis_tlast;
    assign w_short     = s_axis_tlast && !w_last_slot;

    always_comb begin
        w_tuser                  = '0;
        w_tuser[TUSER_SHORT_BIT] = w_short;
        w_tuser[TUSER_LONG_BIT]  = w_long;
    end

    // Beat 0 always loads; later beats replace only on a strictly larger magnitude.
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
        logic w_upd;

        cplx_mag_l1 #(
            .CHANNEL_WIDTH(CHANNEL_WIDTH)
        ) u_mag (
            .i_sample(s_axis_tdata[gi*CHANNEL_WIDTH +: CHANNEL_WIDTH]),
            .o_mag   (w_mag[gi])
        );

        assign w_upd         = (r_count == '0) || (w_mag[gi] > r_max[gi]);
        assign w_new_max[gi] = w_upd ? w_mag[gi] : r_max[gi];
        assign w_new_idx[gi] = w_upd ? INDEX_WIDTH'(r_count) : r_idx[gi];
        assign w_summary[gi*CHANNEL_WIDTH +: CHANNEL_WIDTH] = pack_field(w_new_idx[gi], w_new_max[gi]);
    end

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_ACCUM:   if (w_s_hs && w_burst_end)  w_next_state = ST_OUTPUT;
            ST_OUTPUT:  if (w_m_hs)                 w_next_state = r_discard ? ST_DISCARD : ST_ACCUM;
            ST_DISCARD: if (w_s_hs && s_axis_tlast) w_next_state = ST_ACCUM;
            default:                                w_next_state = ST_ACCUM;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_ACCUM;
            r_count    <= '0;
            r_discard  <= 1'b0;
            r_s_tready <= 1'b1;
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tuser  <= '0;
            for (int n = 0; n < NUM_CHANNELS; n++) begin
                r_max[n] <= '0;
                r_idx[n] <= '0;
            end
        end else begin
            r_state    <= w_next_state;
            r_s_tready <= (w_next_state != ST_OUTPUT);
            r_m_tvalid <= (w_next_state == ST_OUTPUT);

            if (r_state == ST_ACCUM && w_s_hs) begin
                for (int n = 0; n < NUM_CHANNELS; n++) begin
                    r_max[n] <= w_new_max[n];
                    r_idx[n] <= w_new_idx[n];
                end
                if (w_burst_end) begin
                    r_count   <= '0;
                    r_m_tdata <= w_summary;
                    r_m_tuser <= w_tuser;
                    r_discard <= w_long;
                end else begin
                    r_count <= r_count + CNT_W'(1);
                end
            end

            if (r_state == ST_OUTPUT && w_m_hs)
                r_discard <= 1'b0;
        end
    end

    assign s_axis_tready = r_s_tready;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tuser  = r_m_tuser;

endmodule
